irq_request: RTL and testbench



---
 rtl/irq_pkg.sv | 11 +
 rtl/irq_edge_detect.sv | 16 +
 rtl/irq_request.sv | 59 +++++
 tb/tb_irq_request.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// irq_pkg: IF register layout and address shared by the interrupt request block.
package irq_pkg;
  localparam int IF_W = 5;
  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT = 1;
  localparam int IRQ_TIMER = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;
  localparam logic [15:0] IF_ADDR = 16'hFF0F;
  localparam logic [7:0] IF_UNUSED_MASK = 8'hE0;
endpackage

// File: rtl/irq_edge_detect.sv
// irq_edge_detect: history-register edge detector, rising or falling, with selectable reset load.
module irq_edge_detect #(
  parameter int W = 1,
  parameter bit FALL = 1'b0,
  parameter bit RST_LOAD = 1'b1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] pulse
);
  logic [W-1:0] prev;
  always_ff @(posedge clk) prev <= (rst && !RST_LOAD) ? RST_VAL : d;
  assign pulse = FALL ? prev & ~d : d & ~prev;
endmodule

// File: rtl/irq_request.sv
// irq_request: IF register (FF0F) collecting peripheral interrupt events for the CPU core.
// Define IRQ_JOYPAD_DEBOUNCE_EN to require DEBOUNCE_CYCLES low cycles before a joypad request.
module irq_request
  import irq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        SYNC_RES,
  input  logic [15:0] A,
  input  logic [7:0]  D_in,
  input  logic        WR,
  input  logic        RD,
  output logic [7:0]  D_out,
  output logic        D_OE,
  input  logic        VBLANK_IRQ,
  input  logic        STAT_IRQ,
  input  logic        TIMER_IRQ,
  input  logic        SERIAL_IRQ,
  input  logic [3:0]  JOY_P1X,
  output logic [7:0]  CPU_IRQ_TRIG,
  input  logic [7:0]  CPU_IRQ_ACK,
  output logic        JOY_WAKE
);
  logic [IF_W-1:0] if_q, ack_q, ack_rise, evt;
  logic [3:0] src, src_rise;
  logic [1:0] joy_sync;
  logic joy_evt, wr_if, unused_hi;
  assign src = {SERIAL_IRQ, TIMER_IRQ, STAT_IRQ, VBLANK_IRQ};
  for (genvar i = 0; i < 4; i++) begin : g_src
    irq_edge_detect u_ed (.clk(CLK), .rst(SYNC_RES), .d(src[i]), .pulse(src_rise[i]));
  end
  // ack is registered before edge detection so a clear lands one cycle after the ack rises
  always_ff @(posedge CLK) ack_q <= CPU_IRQ_ACK[IF_W-1:0];
  irq_edge_detect #(.W(IF_W)) u_ack (.clk(CLK), .rst(SYNC_RES), .d(ack_q), .pulse(ack_rise));
  always_ff @(posedge CLK) joy_sync <= SYNC_RES ? 2'b11 : {joy_sync[0], &JOY_P1X};
`ifdef IRQ_JOYPAD_DEBOUNCE_EN
  logic [4:0] cnt;
  logic joy_hit;
  always_ff @(posedge CLK) begin
    cnt <= (SYNC_RES || joy_sync[1]) ? '0 : (cnt == 5'(DEBOUNCE_CYCLES)) ? cnt : cnt + 5'd1;
    joy_hit <= !SYNC_RES && !joy_sync[1] && cnt == 5'(DEBOUNCE_CYCLES - 1);
  end
  assign joy_evt = joy_hit;
`else
  irq_edge_detect #(.FALL(1'b1), .RST_LOAD(1'b0), .RST_VAL(1'b1)) u_joy (
    .clk(CLK), .rst(SYNC_RES), .d(joy_sync[1]), .pulse(joy_evt)
  );
`endif
  assign wr_if = WR && A == IF_ADDR;
  assign evt = {joy_evt, src_rise};
  // events beat writes, writes beat ack clears
  always_ff @(posedge CLK) if_q <= SYNC_RES ? '0 : evt | (wr_if ? D_in[IF_W-1:0] : if_q & ~ack_rise);
  assign CPU_IRQ_TRIG = {3'b000, if_q};
  assign D_out = IF_UNUSED_MASK | {3'b000, if_q};
  assign D_OE = RD && A == IF_ADDR && !SYNC_RES;
  assign JOY_WAKE = joy_evt && !SYNC_RES;
  assign unused_hi = &{1'b0, D_in[7:5], CPU_IRQ_ACK[7:5]};
endmodule

// File: tb/tb_irq_request.sv
// tb_irq_request: scenario tasks with a scoreboard of expected {JOY_WAKE, CPU_IRQ_TRIG}.
module tb_irq_request;
  import irq_pkg::*;
  typedef struct packed {
    logic [3:0] src;
    logic [3:0] joy;
    logic [7:0] ack;
    logic       wr;
    logic [7:0] d;
    logic [8:0] exp;
  } vec_t;
  logic CLK = 1'b0, SYNC_RES = 1'b1, WR = 1'b0, RD = 1'b0;
  logic [15:0] A = IF_ADDR;
  logic [7:0] D_in = '0, D_out, CPU_IRQ_TRIG, CPU_IRQ_ACK = '0;
  logic D_OE, JOY_WAKE;
  logic VBLANK_IRQ = 1'b0, STAT_IRQ = 1'b0, TIMER_IRQ = 1'b0, SERIAL_IRQ = 1'b0;
  logic [3:0] JOY_P1X = 4'hF;
  int n_cmp = 0, n_bad = 0;
  logic [8:0] exp_q[$];

  irq_request #(.DEBOUNCE_CYCLES(16)) dut (
    .CLK(CLK), .SYNC_RES(SYNC_RES), .A(A), .D_in(D_in), .WR(WR), .RD(RD),
    .D_out(D_out), .D_OE(D_OE), .VBLANK_IRQ(VBLANK_IRQ), .STAT_IRQ(STAT_IRQ),
    .TIMER_IRQ(TIMER_IRQ), .SERIAL_IRQ(SERIAL_IRQ), .JOY_P1X(JOY_P1X),
    .CPU_IRQ_TRIG(CPU_IRQ_TRIG), .CPU_IRQ_ACK(CPU_IRQ_ACK), .JOY_WAKE(JOY_WAKE)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply(input vec_t v);
    {SERIAL_IRQ, TIMER_IRQ, STAT_IRQ, VBLANK_IRQ} = v.src;
    JOY_P1X = v.joy;
    CPU_IRQ_ACK = v.ack;
    WR = v.wr;
    D_in = v.d;
    A = IF_ADDR;
    exp_q.push_back(v.exp);
  endtask

  task automatic test_reset();
    logic [8:0] e;
    SYNC_RES = 1'b1; VBLANK_IRQ = 1'b1; RD = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({D_OE, JOY_WAKE, CPU_IRQ_TRIG} !== 10'h000) begin
      n_bad++; $display("FAIL reset_outputs oe_wake_trig=%h exp=000", {D_OE, JOY_WAKE, CPU_IRQ_TRIG});
    end
    SYNC_RES = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(9'h000);
      tick();
      e = exp_q.pop_front(); n_cmp++;
      if ({JOY_WAKE, CPU_IRQ_TRIG} !== e) begin
        n_bad++; $display("FAIL reset_hold[%0d] wake_trig=%h exp=%h", i, {JOY_WAKE, CPU_IRQ_TRIG}, e);
      end
    end
    n_cmp++;
    if ({D_OE, D_out} !== 9'h1E0) begin
      n_bad++; $display("FAIL reset_read oe_dout=%h exp=1e0", {D_OE, D_out});
    end
    RD = 1'b0;
  endtask

  task automatic test_timer();
    vec_t t [6] = '{
      {4'h0, 4'hF, 8'h00, 1'b0, 8'h00, 9'h000}, {4'h0, 4'hF, 8'h00, 1'b0, 8'h00, 9'h000},
      {4'h0, 4'hF, 8'h00, 1'b0, 8'h00, 9'h000}, {4'h0, 4'hF, 8'h00, 1'b0, 8'h00, 9'h000},
      {4'h4, 4'hF, 8'h00, 1'b0, 8'h00, 9'h004}, {4'h0, 4'hF, 8'h00, 1'b0, 8'h00, 9'h004}
    };
    logic [8:0] e;
    foreach (t[i]) begin
      apply(t[i]); tick();
      e = exp_q.pop_front(); n_cmp++;
      if ({JOY_WAKE, CPU_IRQ_TRIG} !== e) begin
        n_bad++; $display("FAIL timer[%0d] wake_trig=%h exp=%h", i, {JOY_WAKE, CPU_IRQ_TRIG}, e);
      end
    end
    RD = 1'b1; #1;
    n_cmp++;
    if ({D_OE, D_out} !== 9'h1E4) begin
      n_bad++; $display("FAIL timer_read oe_dout=%h exp=1e4", {D_OE, D_out});
    end
    RD = 1'b0;
  endtask

  task automatic test_ack();
    vec_t t [15] = '{
      {4'h0, 4'hF, 8'h00, 1'b1, 8'h00, 9'h000}, {4'h9, 4'hF, 8'h00, 1'b0, 8'h00, 9'h009},
      {4'h0, 4'hF, 8'h01, 1'b0, 8'h00, 9'h009}, {4'h0, 4'hF, 8'h01, 1'b0, 8'h00, 9'h008},
      {4'h1, 4'hF, 8'h01, 1'b0, 8'h00, 9'h009}, {4'h1, 4'hF, 8'h00, 1'b0, 8'h00, 9'h009},
      {4'h0, 4'hF, 8'h08, 1'b0, 8'h00, 9'h009}, {4'h0, 4'hF, 8'h00, 1'b0, 8'h00, 9'h001},
      {4'h0, 4'hF, 8'hFF, 1'b0, 8'h00, 9'h001}, {4'h0, 4'hF, 8'h00, 1'b0, 8'h00, 9'h000},
      {4'h0, 4'hF, 8'h00, 1'b1, 8'h04, 9'h004}, {4'h0, 4'hF, 8'h04, 1'b0, 8'h00, 9'h004},
      {4'h4, 4'hF, 8'h04, 1'b0, 8'h00, 9'h004}, {4'h0, 4'hF, 8'h00, 1'b0, 8'h00, 9'h004},
      {4'h0, 4'hF, 8'h00, 1'b1, 8'h00, 9'h000}
    };
    logic [8:0] e;
    foreach (t[i]) begin
      apply(t[i]); tick();
      e = exp_q.pop_front(); n_cmp++;
      if ({JOY_WAKE, CPU_IRQ_TRIG} !== e) begin
        n_bad++; $display("FAIL ack[%0d] wake_trig=%h exp=%h", i, {JOY_WAKE, CPU_IRQ_TRIG}, e);
      end
    end
  endtask

  task automatic test_write();
    vec_t t [3] = '{
      {4'h0, 4'hF, 8'h00, 1'b1, 8'hFF, 9'h01F}, {4'h2, 4'hF, 8'h00, 1'b1, 8'h00, 9'h002},
      {4'h0, 4'hF, 8'h00, 1'b0, 8'h00, 9'h002}
    };
    logic [8:0] e;
    foreach (t[i]) begin
      apply(t[i]); tick();
      e = exp_q.pop_front(); n_cmp++;
      if ({JOY_WAKE, CPU_IRQ_TRIG} !== e) begin
        n_bad++; $display("FAIL write[%0d] wake_trig=%h exp=%h", i, {JOY_WAKE, CPU_IRQ_TRIG}, e);
      end
    end
    A = 16'hFF0E; WR = 1'b1; D_in = 8'h1F; RD = 1'b1;
    exp_q.push_back(9'h002);
    #1;
    n_cmp++;
    if (D_OE !== 1'b0) begin
      n_bad++; $display("FAIL write_other_oe oe=%b exp=0", D_OE);
    end
    tick(); WR = 1'b0; A = IF_ADDR; #1;
    e = exp_q.pop_front(); n_cmp++;
    if ({JOY_WAKE, CPU_IRQ_TRIG} !== e) begin
      n_bad++; $display("FAIL write_other_addr wake_trig=%h exp=%h", {JOY_WAKE, CPU_IRQ_TRIG}, e);
    end
    n_cmp++;
    if ({D_OE, D_out} !== 9'h1E2) begin
      n_bad++; $display("FAIL write_read oe_dout=%h exp=1e2", {D_OE, D_out});
    end
    RD = 1'b0;
  endtask

  task automatic test_back_to_back();
    vec_t t [7] = '{
      {4'h0, 4'hF, 8'h00, 1'b1, 8'h00, 9'h000}, {4'hF, 4'hF, 8'h00, 1'b0, 8'h00, 9'h00F},
      {4'h0, 4'hF, 8'h0F, 1'b0, 8'h00, 9'h00F}, {4'h0, 4'hF, 8'h00, 1'b0, 8'h00, 9'h000},
      {4'h5, 4'hF, 8'h00, 1'b0, 8'h00, 9'h005}, {4'h0, 4'hF, 8'h00, 1'b0, 8'h00, 9'h005},
      {4'h0, 4'hF, 8'h00, 1'b1, 8'h00, 9'h000}
    };
    logic [8:0] e;
    foreach (t[i]) begin
      apply(t[i]); tick();
      e = exp_q.pop_front(); n_cmp++;
      if ({JOY_WAKE, CPU_IRQ_TRIG} !== e) begin
        n_bad++; $display("FAIL b2b[%0d] wake_trig=%h exp=%h", i, {JOY_WAKE, CPU_IRQ_TRIG}, e);
      end
    end
  endtask

`ifdef IRQ_JOYPAD_DEBOUNCE_EN
  task automatic test_debounce();
    vec_t v;
    logic [8:0] e;
    for (int i = 0; i < 85; i++) begin
      if (i < 10) v = {4'h0, 4'hE, 8'h00, 1'b0, 8'h00, 9'h000};
      else if (i < 40) v = {4'h0, 4'hF, 8'h00, 1'b0, 8'h00, 9'h000};
      else if (i < 60) v = {4'h0, 4'hE, 8'h00, 1'b0, 8'h00, (i == 57) ? 9'h100 : (i >= 58) ? 9'h010 : 9'h000};
      else if (i < 84) v = {4'h0, 4'hF, 8'h00, 1'b0, 8'h00, 9'h010};
      else v = {4'h0, 4'hF, 8'h00, 1'b1, 8'h00, 9'h000};
      apply(v); tick();
      e = exp_q.pop_front(); n_cmp++;
      if ({JOY_WAKE, CPU_IRQ_TRIG} !== e) begin
        n_bad++; $display("FAIL debounce[%0d] wake_trig=%h exp=%h", i, {JOY_WAKE, CPU_IRQ_TRIG}, e);
      end
    end
  endtask
`else
  task automatic test_joypad();
    vec_t t [11] = '{
      {4'h0, 4'hE, 8'h00, 1'b0, 8'h00, 9'h000}, {4'h0, 4'hE, 8'h00, 1'b0, 8'h00, 9'h100},
      {4'h0, 4'hE, 8'h00, 1'b0, 8'h00, 9'h010}, {4'h0, 4'hE, 8'h00, 1'b0, 8'h00, 9'h010},
      {4'h0, 4'hF, 8'h00, 1'b0, 8'h00, 9'h010}, {4'h0, 4'hF, 8'h00, 1'b0, 8'h00, 9'h010},
      {4'h0, 4'hF, 8'h00, 1'b1, 8'h00, 9'h000}, {4'h0, 4'h7, 8'h00, 1'b0, 8'h00, 9'h000},
      {4'h0, 4'h7, 8'h00, 1'b0, 8'h00, 9'h100}, {4'h0, 4'hF, 8'h00, 1'b0, 8'h00, 9'h010},
      {4'h0, 4'hF, 8'h00, 1'b1, 8'h00, 9'h000}
    };
    logic [8:0] e;
    foreach (t[i]) begin
      apply(t[i]); tick();
      e = exp_q.pop_front(); n_cmp++;
      if ({JOY_WAKE, CPU_IRQ_TRIG} !== e) begin
        n_bad++; $display("FAIL joypad[%0d] wake_trig=%h exp=%h", i, {JOY_WAKE, CPU_IRQ_TRIG}, e);
      end
    end
  endtask
`endif

  task automatic test_mid_reset();
    logic [8:0] e;
    apply({4'h0, 4'hF, 8'h00, 1'b1, 8'h1F, 9'h01F}); tick();
    e = exp_q.pop_front(); n_cmp++;
    if ({JOY_WAKE, CPU_IRQ_TRIG} !== e) begin
      n_bad++; $display("FAIL mid_reset_set wake_trig=%h exp=%h", {JOY_WAKE, CPU_IRQ_TRIG}, e);
    end
    WR = 1'b0; SYNC_RES = 1'b1; VBLANK_IRQ = 1'b1; RD = 1'b1;
    tick();
    n_cmp++;
    if ({D_OE, JOY_WAKE, CPU_IRQ_TRIG} !== 10'h000) begin
      n_bad++; $display("FAIL mid_reset oe_wake_trig=%h exp=000", {D_OE, JOY_WAKE, CPU_IRQ_TRIG});
    end
    SYNC_RES = 1'b0; RD = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(9'h000);
      tick();
      e = exp_q.pop_front(); n_cmp++;
      if ({JOY_WAKE, CPU_IRQ_TRIG} !== e) begin
        n_bad++; $display("FAIL mid_reset_release[%0d] wake_trig=%h exp=%h", i, {JOY_WAKE, CPU_IRQ_TRIG}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_timer();
    test_ack();
    test_write();
    test_back_to_back();
`ifdef IRQ_JOYPAD_DEBOUNCE_EN
    test_debounce();
`else
    test_joypad();
`endif
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
